// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    counter;
  logic             borrow;
  logic             d;
  logic             borrow_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    full_sub = {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
  endfunction

  // Current bit of the difference and the borrow into the next bit.
  always_comb begin
    {borrow_next, d} = full_sub(a_sh[0], b_sh[0], borrow);
    res_next         = {d, {(WIDTH-1){1'b0}}} | (res_sh >> 1);
  end

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_sh         <= {WIDTH{1'b0}};
      b_sh         <= {WIDTH{1'b0}};
      res_sh       <= {WIDTH{1'b0}};
      counter      <= {CW{1'b0}};
      borrow       <= 1'b0;
      diff         <= {WIDTH{1'b0}};
      bout         <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      start_ready  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      ovf          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh        <= a;
            b_sh        <= b;
            res_sh      <= {WIDTH{1'b0}};
            borrow      <= bin;
            counter     <= {CW{1'b0}};
            busy        <= 1'b1;
            start_ready <= 1'b0;
            state       <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb       <= a[WIDTH-1];
            b_msb       <= b[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= res_next;
          borrow  <= borrow_next;
          counter <= counter + {{(CW-1){1'b0}}, 1'b1};
          // The last bit is processed this cycle; publish the result directly.
          if (counter == CW'(WIDTH - 1)) begin
            state        <= DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            diff         <= res_next;
            bout         <= borrow_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf          <= (a_msb ^ b_msb) & (d ^ a_msb);
`endif
          end else begin
            state <= SHIFT;
          end
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
          start_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing a − b − bin, one bit per clock, LSB first.
- Uses a single full-subtractor cell and a registered borrow; it is the subtract-direction counterpart of the team's gate-level full adder.
- Sits in the lab ALU datapath as a low-area arithmetic unit.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  operand valid; request to begin a subtraction
- start_ready  output  1  high when a new operation can be accepted (state IDLE)
- a  input  WIDTH  minuend, sampled on accept
- b  input  WIDTH  subtrahend, sampled on accept
- bin  input  1  borrow-in, sampled on accept
- diff  output  WIDTH  result a − b − bin, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 when unsigned a < b + bin
- result_valid  output  1  diff/bout valid; held until consumed
- result_ready  input  1  consumer accepts the result
- busy  output  1  high in state SHIFT

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, borrow=0, shift registers=0.
  - diff=0, bout=0, result_valid=0, busy=0, start_ready=1.
  - Applies immediately, including mid-operation; any partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - On a clock edge with start=1: load a_sh←a, b_sh←b, borrow←bin, counter←0; go to SHIFT.
- SHIFT (busy=1, start_ready=0, start ignored):
  - Each cycle uses x=a_sh[0], y=b_sh[0].
  - d = x ^ y ^ borrow.
  - borrow_next = (~x & y) | (~(x ^ y) & borrow).
  - a_sh and b_sh shift right by 1. The result shift register shifts right with d entering at the MSB.
  - counter increments. When counter==WIDTH−1, that cycle processes the last bit and the next state is DONE.
- DONE:
  - result_valid=1; diff = result shift register; bout = final borrow.
  - Stay in DONE while result_ready=0; diff and bout stay stable.
  - On result_valid & result_ready at a clock edge, go to IDLE.
- Latency:
  - start accepted at edge k → result_valid rises after edge k+WIDTH.
  - Throughput is 1 operation per WIDTH+2 cycles minimum.
- After returning to IDLE, diff and bout keep their last value until the next operation completes. result_valid is 0 in IDLE and SHIFT.
- start asserted in SHIFT or DONE: no effect. The operation is not queued, and in-flight operands are not disturbed.
- result_ready asserted outside DONE: no effect.
- Operands changing after the accept edge: no effect.
- Width rules:
  - counter is $clog2(WIDTH) bits.
  - diff wraps modulo 2^WIDTH; no saturation.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), signed two's-complement overflow of a − b − bin.
  - ovf = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]), computed from a copy of a[MSB] and b[MSB] registered at accept.
  - ovf is registered; valid with result_valid, held stable in DONE, reset to 0.
- Not defined:
  - Port ovf does not exist and no extra flops are built.
  - All other behaviour is identical.

Test Plan:
1. Reset then a=100, b=37, bin=0, start 1 cycle → after 9 edges result_valid=1, diff=63, bout=0; with result_ready=1, back to IDLE next edge with start_ready=1.
2. a=5, b=10, bin=0 → diff=251 (0xFB), bout=1. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
3. Back-pressure: a=0xAA, b=0x55, result_ready=0 for 5 cycles after valid → diff=0x55, bout=0, held stable with result_valid=1 for all 5 cycles; consumed on the first edge with result_ready=1.
4. Busy rejection: start with a=20, b=3, then raise start again with a=9, b=9 during SHIFT → result is diff=17; exactly one result_valid pulse/handshake occurs.
5. Reset mid-operation: deassert rst_n at SHIFT cycle 4 → outputs 0 and state IDLE immediately. New op a=1, b=1 after release → diff=0, bout=0.
6. With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 → diff=0x7F, ovf=1, bout=0. Then a=0x7F, b=0xFF → diff=0x80, ovf=1, bout=1. Then a=3, b=1 → ovf=0.
